// File: rtl/button_event_arbiter_pkg.sv
// Shared types and helpers for the button event arbiter: FSM states, event
// kinds and the round-robin pick function.
package button_event_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  localparam logic KIND_PRESS  = 1'b0;
  localparam logic KIND_REPEAT = 1'b1;

  localparam int MAX_BUTTONS = 8;

  // First set request after index 'last', wrapping modulo n; -1 when none.
  function automatic int rr_pick(input logic [MAX_BUTTONS-1:0] req,
                                 input int last,
                                 input int n);
    int idx;
    rr_pick = -1;
    for (int k = 1; k <= MAX_BUTTONS; k++) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (rr_pick < 0 && req[idx[2:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/button_event_arbiter_hold_tracker.sv
// Per-button edge detector and hold/repeat timer producing a coalescing
// pending flag plus the kind (press/repeat) of the pending event.
module button_hold_tracker
  import button_event_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  input  logic clr,
  output logic pending,
  output logic kind
);

  localparam bit REPEAT_EN = (HOLD_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_RELOAD =
    CNT_WIDTH'((HOLD_CYCLES >= REPEAT_CYCLES) ? HOLD_CYCLES - REPEAT_CYCLES : 0);

  logic                 prev;
  logic                 rise;
  logic                 fire;
  logic [CNT_WIDTH-1:0] cnt;

  assign rise = btn_level & ~prev;
  assign fire = REPEAT_EN && btn_level && !rise && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev    <= 1'b0;
      cnt     <= '0;
      pending <= 1'b0;
      kind    <= KIND_PRESS;
    end else begin
      prev <= btn_level;

      // Reload on fire keeps the counter from ever passing CNT_LAST.
      if (!btn_level || rise)
        cnt <= '0;
      else if (fire)
        cnt <= CNT_RELOAD;
      else if (REPEAT_EN)
        cnt <= cnt + CNT_WIDTH'(1);

      // New events beat the arbiter's clear; a pending press is never downgraded.
      if (rise) begin
        pending <= 1'b1;
        kind    <= KIND_PRESS;
      end else if (fire) begin
        pending <= 1'b1;
        if (clr || !pending || kind != KIND_PRESS) kind <= KIND_REPEAT;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter sharing one valid/ready event channel among the
// per-button hold trackers.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS   = 4,
  parameter int unsigned ID_WIDTH      = 2,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_level,
  input  logic                   evt_ready,
  output logic                   evt_valid,
  output logic [ID_WIDTH-1:0]    evt_id,
  output logic                   evt_repeat,
  output logic [NUM_BUTTONS-1:0] pending
);

  arb_state_t                 state_q, state_d;
  logic [ID_WIDTH-1:0]        last_grant, grant_d;
  logic [ID_WIDTH-1:0]        id_d;
  logic                       valid_d;
  logic                       rep_d;
  logic [NUM_BUTTONS-1:0]     clr;
  logic [NUM_BUTTONS-1:0]     kind;
  int                         pick;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_hold_tracker #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_WIDTH     (CNT_WIDTH)
    ) u_tracker (
      .clk       (clk),
      .reset     (reset),
      .btn_level (btn_level[i]),
      .clr       (clr[i]),
      .pending   (pending[i]),
      .kind      (kind[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_repeat <= KIND_PRESS;
      last_grant <= ID_WIDTH'(NUM_BUTTONS - 1);
    end else begin
      state_q    <= state_d;
      evt_valid  <= valid_d;
      evt_id     <= id_d;
      evt_repeat <= rep_d;
      last_grant <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = evt_valid;
    id_d    = evt_id;
    rep_d   = evt_repeat;
    grant_d = last_grant;
    clr     = '0;
    pick    = rr_pick(MAX_BUTTONS'(pending), int'(last_grant), int'(NUM_BUTTONS));

    case (state_q)
      ST_IDLE: begin
        if (pick >= 0) begin
          id_d = ID_WIDTH'(pick);
          for (int i = 0; i < NUM_BUTTONS; i++)
            if (pick == i) rep_d = kind[i];
          valid_d = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // Offer stays frozen until accepted; releases do not withdraw it.
        if (evt_ready) begin
          for (int i = 0; i < NUM_BUTTONS; i++)
            if (evt_id == ID_WIDTH'(i)) clr[i] = 1'b1;
          grant_d = evt_id;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with an event scoreboard queue.
module tb_button_event_arbiter;

  localparam int NB  = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NB-1:0]  btn_level;
  logic           evt_ready;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_repeat;
  logic [NB-1:0]  pending;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;
  logic [6:0] vpat;

  button_event_arbiter #(
    .NUM_BUTTONS   (NB),
    .ID_WIDTH      (IDW),
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .CNT_WIDTH     (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_level  (btn_level),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_id     (evt_id),
    .evt_repeat (evt_repeat),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_evt(input logic [1:0] id, input logic rep);
    exp_q.push_back({id, rep});
  endtask

  // Every accepted event is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {29'd0, evt_id, evt_repeat}, 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("event_id_kind", {29'd0, evt_id, evt_repeat}, {29'd0, mon_exp});
      end
    end
  end

  initial begin
    reset     = 1'b0;
    btn_level = '0;
    evt_ready = 1'b1;
    #2;
    chk("reset_valid",   32'(evt_valid),  32'd0);
    chk("reset_id",      32'(evt_id),     32'd0);
    chk("reset_repeat",  32'(evt_repeat), 32'd0);
    chk("reset_pending", 32'(pending),    32'd0);

    // Single press on button 1.
    tick(1);
    reset = 1'b1;
    tick(4);
    btn_level = 4'b0010;
    push_evt(2'd1, 1'b0);
    tick(1);
    chk("press_pending", 32'(pending), 32'b0010);
    chk("press_not_yet_valid", 32'(evt_valid), 32'd0);
    tick(1);
    chk("press_offer", 32'({evt_valid, evt_id, evt_repeat}), 32'b1010);
    tick(1);
    chk("press_single_cycle", 32'(evt_valid), 32'd0);
    chk("press_pending_clear", 32'(pending), 32'd0);
    btn_level = '0;

    // Simultaneous presses served round robin from last_grant=3.
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    btn_level = 4'b1011;
    push_evt(2'd0, 1'b0);
    push_evt(2'd1, 1'b0);
    push_evt(2'd3, 1'b0);
    vpat = 7'b0101010;
    for (int k = 0; k < 7; k++) begin
      tick(1);
      if (k == 0) chk("multi_pending", 32'(pending), 32'b1011);
      chk("multi_valid_spacing", 32'(evt_valid), 32'(vpat[k[2:0]]));
    end
    btn_level = '0;

    // Held button 2: press, then repeats at +8 and every 4 cycles.
    tick(2);
    btn_level = 4'b0100;
    push_evt(2'd2, 1'b0);
    for (int k = 0; k < 6; k++) push_evt(2'd2, 1'b1);
    tick(1);
    chk("hold_press_pending", 32'(pending), 32'b0100);
    tick(7);
    chk("hold_no_early_repeat", 32'(pending), 32'd0);
    tick(1);
    chk("hold_first_repeat_pending", 32'(pending), 32'b0100);
    tick(1);
    chk("hold_first_repeat_offer", 32'({evt_valid, evt_id, evt_repeat}), 32'b1101);
    tick(20);
    btn_level = '0;
    tick(20);
    chk("hold_repeat_count", 32'(exp_q.size()), 32'd0);

    // Back-pressure: offer held stable, extra pulses coalesce.
    evt_ready = 1'b0;
    btn_level = 4'b0001;
    push_evt(2'd0, 1'b0);
    tick(1);
    btn_level = '0;
    tick(1);
    for (int k = 0; k < 20; k++) begin
      chk("stall_offer_stable", 32'({evt_valid, evt_id, evt_repeat}), 32'b1000);
      if (k == 7) btn_level = 4'b0001;
      if (k == 8) btn_level = '0;
      if (k == 19) begin
        btn_level = 4'b0001;
        evt_ready = 1'b1;
        push_evt(2'd0, 1'b0);
      end
      tick(1);
    end
    chk("handshake_rise_keeps_pending", 32'(pending), 32'b0001);
    chk("handshake_valid_drop", 32'(evt_valid), 32'd0);
    btn_level = '0;
    tick(1);
    chk("coalesced_press_offer", 32'({evt_valid, evt_id, evt_repeat}), 32'b1000);
    tick(2);

    // Asynchronous reset during an offer drops the event.
    btn_level = 4'b0010;
    tick(2);
    chk("pre_reset_offer", 32'({evt_valid, evt_id, evt_repeat}), 32'b1010);
    reset = 1'b0;
    #1;
    chk("async_reset_valid", 32'(evt_valid), 32'd0);
    chk("async_reset_pending", 32'(pending), 32'd0);
    chk("async_reset_id", 32'(evt_id), 32'd0);
    tick(2);
    reset = 1'b1;
    push_evt(2'd1, 1'b0);
    tick(1);
    chk("held_through_reset_pending", 32'(pending), 32'b0010);
    tick(1);
    chk("held_through_reset_offer", 32'({evt_valid, evt_id, evt_repeat}), 32'b1010);
    tick(1);
    btn_level = '0;
    tick(3);

    // After granting 3, buttons 0 and 3 together: 0 wins first.
    btn_level = 4'b1000;
    push_evt(2'd3, 1'b0);
    tick(1);
    btn_level = '0;
    tick(3);
    btn_level = 4'b1001;
    push_evt(2'd0, 1'b0);
    push_evt(2'd3, 1'b0);
    tick(1);
    btn_level = '0;
    tick(1);
    chk("rr_wrap_first", 32'({evt_valid, evt_id, evt_repeat}), 32'b1000);
    tick(2);
    chk("rr_wrap_second", 32'({evt_valid, evt_id, evt_repeat}), 32'b1110);
    tick(10);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
